// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Sequencing front-end for the shared 32-bit ALU. Two requesters present
// operations over valid/ready handshakes; a round-robin arbiter picks one,
// the block drives the ALU for a single execute cycle and returns the
// registered result and flags on one tagged response channel. Only one
// operation is ever in flight.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req{0,1}_valid / _ready     request handshake (ready is combinational, IDLE only)
//   req{0,1}_op1, _op2, _code   operands and 4-bit ALU control code
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      requester that owns the response
//   rsp_result, rsp_v/n/z       registered ALU result and flags
//   rsp_err                     illegal code, no ALU operation performed
//   alu_op1, alu_op2            operands to the ALU (hold last value outside EXEC)
//   alu_control_code            ALU control, 4'b1111 (NOP) outside EXEC
//   alu_result, alu_*_flag      combinational ALU outputs, sampled in EXEC
// -----------------------------------------------------------------------------
module alu_req_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [3:0]  req0_code,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [3:0]  req1_code,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_v,
  output logic        rsp_n,
  output logic        rsp_z,
  output logic        rsp_err,

  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_control_code,
  input  logic [31:0] alu_result,
  input  logic        alu_v_flag,
  input  logic        alu_n_flag,
  input  logic        alu_z_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CODE_NOP = 4'b1111;
  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_SUB = 4'b0110;

  // Codes the ALU actually implements; anything else is answered with rsp_err.
  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1001, 4'b1100, 4'b1101: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // The ALU only updates its flags for ADD and SUB; for everything else the
  // flag inputs are stale and must not leak into the response.
  function automatic logic flags_meaningful(input logic [3:0] code);
    flags_meaningful = (code == CODE_ADD) || (code == CODE_SUB);
  endfunction

  state_t      state;
  logic        last_id;   // requester served most recently (priority pointer)
  logic [3:0]  cap_code;  // code of the operation in flight
  logic        cap_id;    // owner of the operation in flight

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic        grant_valid;
  logic        grant_id;
  logic        accept;
  logic [31:0] sel_op1;
  logic [31:0] sel_op2;
  logic [3:0]  sel_code;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here via the defaults at the top) so no latch is inferred.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      // Contention: favour whoever was not served last.
      grant_id = ~last_id;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Reset overrides the handshake so nothing is accepted in the reset cycle.
  assign accept     = (state == IDLE) && !reset && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  assign sel_op1  = grant_id ? req1_op1  : req0_op1;
  assign sel_op2  = grant_id ? req1_op2  : req0_op2;
  assign sel_code = grant_id ? req1_code : req0_code;

  // ---------------------------------------------------------------------------
  // Sequencer: single FSM with all outputs registered
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last_id          <= 1'b1;     // so req0 wins the first contention
      cap_code         <= CODE_NOP;
      cap_id           <= 1'b0;
      alu_op1          <= '0;
      alu_op2          <= '0;
      alu_control_code <= CODE_NOP;
      rsp_valid        <= 1'b0;
      rsp_id           <= 1'b0;
      rsp_result       <= '0;
      rsp_v            <= 1'b0;
      rsp_n            <= 1'b0;
      rsp_z            <= 1'b0;
      rsp_err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cap_id   <= grant_id;
            cap_code <= sel_code;
            if (is_legal(sel_code)) begin
              // Operands and code go straight onto the ALU pins, which then
              // hold them for the single EXEC cycle.
              alu_op1          <= sel_op1;
              alu_op2          <= sel_op2;
              alu_control_code <= sel_code;
              state            <= EXEC;
            end else begin
              // Illegal code: skip the ALU and answer immediately.
              rsp_id     <= grant_id;
              rsp_result <= '0;
              rsp_v      <= 1'b0;
              rsp_n      <= 1'b0;
              rsp_z      <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end

        EXEC: begin
          rsp_id           <= cap_id;
          rsp_result       <= alu_result;
          rsp_v            <= flags_meaningful(cap_code) && alu_v_flag;
          rsp_n            <= flags_meaningful(cap_code) && alu_n_flag;
          rsp_z            <= flags_meaningful(cap_code) && alu_z_flag;
          rsp_err          <= 1'b0;
          rsp_valid        <= 1'b1;
          alu_control_code <= CODE_NOP;
          state            <= RESP;
        end

        RESP: begin
          // rsp_* stay untouched here so they are stable under back-pressure.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last_id   <= rsp_id;
            state     <= IDLE;
          end
        end

        default: begin
          state            <= IDLE;
          rsp_valid        <= 1'b0;
          alu_control_code <= CODE_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Self-checking bench for alu_req_arbiter. The bench plays the ALU (a
// combinational model that leaves deliberately wrong "stale" flags for codes
// other than ADD/SUB) and keeps a transaction-level reference model: whether
// an operation is outstanding, how many cycles since it was accepted, the
// expected response computed from the request with plain arithmetic, and the
// round-robin pointer. Every cycle the model's expectations are compared with
// the DUT outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_code, req1_code;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_v, rsp_n, rsp_z, rsp_err;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_control_code;
  logic        alu_v_flag, alu_n_flag, alu_z_flag;

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req0_op1         (req0_op1),
    .req0_op2         (req0_op2),
    .req0_code        (req0_code),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .req1_op1         (req1_op1),
    .req1_op2         (req1_op2),
    .req1_code        (req1_code),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_result       (rsp_result),
    .rsp_v            (rsp_v),
    .rsp_n            (rsp_n),
    .rsp_z            (rsp_z),
    .rsp_err          (rsp_err),
    .alu_op1          (alu_op1),
    .alu_op2          (alu_op2),
    .alu_control_code (alu_control_code),
    .alu_result       (alu_result),
    .alu_v_flag       (alu_v_flag),
    .alu_n_flag       (alu_n_flag),
    .alu_z_flag       (alu_z_flag)
  );

  // ---------------------------------------------------------------------------
  // Arithmetic reference for the ALU operations
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b0110: alu_fn = a - b;
      4'b0111: alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: alu_fn = ~(a | b);
      4'b1100: alu_fn = ~(a & b);
      4'b1101: alu_fn = a ^ b;
      default: alu_fn = 32'hDEAD_BEEF;
    endcase
  endfunction

  // {v, n, z} for ADD / SUB
  function automatic logic [2:0] arith_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
    logic [31:0] r;
    logic        v;
    if (c == 4'b0010) begin
      r = a + b;
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r = a - b;
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    arith_flags = {v, r[31], (r == 32'd0)};
  endfunction

  function automatic logic is_add_sub(input logic [3:0] c);
    is_add_sub = (c == 4'b0010) || (c == 4'b0110);
  endfunction

  function automatic logic legal(input logic [3:0] c);
    legal = c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110,
                      4'b0111, 4'b1001, 4'b1100, 4'b1101};
  endfunction

  // Bench-side ALU: flags are forced to 1 for non-arithmetic codes to mimic
  // stale values the DUT must mask.
  assign alu_result = alu_fn(alu_op1, alu_op2, alu_control_code);
  assign {alu_v_flag, alu_n_flag, alu_z_flag} =
    is_add_sub(alu_control_code) ? arith_flags(alu_op1, alu_op2, alu_control_code) : 3'b111;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [2:0]  vnz;
    logic [31:0] result;
  } rsp_t;

  function automatic rsp_t ref_rsp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] c);
    rsp_t e;
    e.id = id;
    if (!legal(c)) begin
      e.err    = 1'b1;
      e.vnz    = 3'b000;
      e.result = 32'd0;
    end else begin
      e.err    = 1'b0;
      e.vnz    = is_add_sub(c) ? arith_flags(a, b, c) : 3'b000;
      e.result = alu_fn(a, b, c);
    end
    ref_rsp = e;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model state and bookkeeping
  // ---------------------------------------------------------------------------
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic        m_busy;
  int          m_age;        // cycles since the acceptance edge
  int          m_lat;        // 2 for legal codes, 1 for illegal
  rsp_t        m_exp;
  logic [3:0]  m_code;
  logic [31:0] m_op1, m_op2;
  int          m_last;       // id served most recently
  int          grant_log[$];
  int          grant_cyc[$];
  int          rel_cyc;
  rsp_t        seen_rsp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    if (id == 0) begin
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_code = c;
    end else begin
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_code = c;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) rand_operand = corners[$urandom_range(0, 4)];
    else                           rand_operand = $urandom;
  endfunction

  task automatic rand_req(input int id);
    logic [3:0] codes [8];
    logic [3:0] c;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1001, 4'b1100, 4'b1101};
    if ($urandom_range(0, 4) == 0) c = 4'($urandom_range(0, 15));
    else                           c = codes[$urandom_range(0, 7)];
    set_req(id, 1'b1, rand_operand(), rand_operand(), c);
  endtask

  // One clock cycle: compare DUT outputs with the model on the falling edge,
  // advance the model across the rising edge, then retire an accepted request.
  task automatic step();
    int   g;
    logic rv;
    rsp_t obs;
    g  = -1;
    rv = 1'b0;
    @(negedge clk);
    obs = {rsp_id, rsp_err, rsp_v, rsp_n, rsp_z, rsp_result};
    if (reset) begin
      check("ready_in_reset", 64'({req0_ready, req1_ready}), 64'(2'b00));
    end else if (!m_busy) begin
      if (req0_valid && req1_valid) g = 1 - m_last;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      check("ready_idle", 64'({req0_ready, req1_ready}), 64'({g == 0, g == 1}));
      check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
      check("alu_code_idle", 64'(alu_control_code), 64'(4'hF));
    end else begin
      rv = (m_age >= m_lat);
      check("ready_busy", 64'({req0_ready, req1_ready}), 64'(2'b00));
      check("rsp_valid", 64'(rsp_valid), 64'(rv));
      if (rv) check("rsp_fields", 64'(obs), 64'(m_exp));
      if (m_lat == 2 && m_age == 1) begin
        check("alu_code_exec", 64'(alu_control_code), 64'(m_code));
        check("alu_operands", {alu_op1, alu_op2}, {m_op1, m_op2});
      end else begin
        check("alu_code_nop", 64'(alu_control_code), 64'(4'hF));
      end
    end

    @(posedge clk);
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_op1  = (g == 1) ? req1_op1  : req0_op1;
        m_op2  = (g == 1) ? req1_op2  : req0_op2;
        m_code = (g == 1) ? req1_code : req0_code;
        m_exp  = ref_rsp(g[0], m_op1, m_op2, m_code);
        m_lat  = legal(m_code) ? 2 : 1;
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end
    end else if (rv && rsp_ready) begin
      seen_rsp = obs;
      rel_cyc  = cyc;
      m_busy   = 1'b0;
      m_last   = int'(m_exp.id);
    end else begin
      m_age++;
    end

    #1;
    if (g == 0) req0_valid = 1'b0;
    if (g == 1) req1_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] order;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    m_busy = 1'b0;
    m_age  = 0;
    m_lat  = 2;
    m_last = 1;
    m_exp  = '0;
    m_code = 4'hF;
    m_op1  = '0;
    m_op2  = '0;
    rel_cyc = 0;
    seen_rsp = '0;

    repeat (2) step();
    reset = 1'b0;

    // Reset values of every output.
    check("reset_rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_v, rsp_n, rsp_z, rsp_result}), 64'(0));
    check("reset_alu_ops", {alu_op1, alu_op2}, 64'(0));
    check("reset_alu_code", 64'(alu_control_code), 64'(4'hF));

    // req0 ADD with signed overflow.
    set_req(0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
    repeat (4) step();
    check("add_overflow", 64'(seen_rsp), 64'({1'b0, 1'b0, 3'b110, 32'h8000_0000}));

    // req1 SUB to zero.
    set_req(1, 1'b1, 32'h5, 32'h5, 4'b0110);
    repeat (4) step();
    check("sub_zero", 64'(seen_rsp), 64'({1'b1, 1'b0, 3'b001, 32'h0}));

    // req1 SLT: -1 < 1, flags masked despite stale ALU flags.
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'b0111);
    repeat (4) step();
    check("slt_signed", 64'(seen_rsp), 64'({1'b1, 1'b0, 3'b000, 32'h1}));

    // Continuous contention right after reset: 0,1,0,1 every 3 cycles.
    reset = 1'b1;
    step();
    reset = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      if (!req0_valid) rand_req(0);
      if (!req1_valid) rand_req(1);
      step();
    end
    check("alt_count", 64'(grant_log.size() >= 4), 64'(1));
    if (grant_log.size() >= 4) begin
      order = {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]};
      check("alt_order", 64'(order), 64'(4'b0101));
      for (int i = 1; i < 4; i++)
        check("alt_interval", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(3));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) step();

    // Back-pressure: hold the response 5 cycles with req0 waiting.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 4'b1101);
    repeat (3) step();
    set_req(0, 1'b1, 32'hA, 32'h3, 4'b0110);
    repeat (5) step();
    rsp_ready = 1'b1;
    repeat (2) step();
    check("release_to_grant", 64'(grant_cyc[$] - rel_cyc), 64'(1));
    repeat (3) step();

    // Illegal code 1111 answers after one cycle with err set.
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111);
    repeat (3) step();
    check("illegal_1111", 64'(seen_rsp), 64'({1'b0, 1'b1, 3'b000, 32'h0}));
    check("illegal_latency", 64'(rel_cyc - grant_cyc[$]), 64'(1));

    // Reset while an operation is in EXEC: it is dropped and req0 regains priority.
    set_req(1, 1'b1, 32'h10, 32'h20, 4'b0010);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_exec_state", 64'({rsp_valid, alu_control_code}), 64'({1'b0, 4'hF}));
    set_req(0, 1'b1, 32'h3, 32'h4, 4'b0001);
    set_req(1, 1'b1, 32'h3, 32'h4, 4'b0000);
    step();
    check("reset_priority", 64'(grant_log[$]), 64'(0));
    repeat (4) step();
    req1_valid = 1'b0;
    repeat (6) step();

    // Randomized traffic with random back-pressure and occasional withdrawals.
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid && $urandom_range(0, 2) == 0) rand_req(0);
      else if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (!req1_valid && $urandom_range(0, 2) == 0) rand_req(1);
      else if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 1'b0;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
